// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the CPU step/run clock-enable controller.
// Holds the FSM state encoding and a counter-width helper.
package cpu_step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debouncer and
// registered one-cycle press pulse on an accepted 0->1 transition.
module btn_debounce
    import cpu_step_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_stable,
    output logic btn_press
);

    localparam int unsigned     CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0      <= 1'b0;
            sync1      <= 1'b0;
            cnt        <= '0;
            btn_stable <= 1'b0;
            btn_press  <= 1'b0;
        end else begin
            sync0     <= btn_raw;
            sync1     <= sync0;
            btn_press <= 1'b0;
            if (sync1 == btn_stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Level accepted; only a rising acceptance is a press.
                btn_stable <= sync1;
                btn_press  <= sync1;
                cnt        <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU core clock-enable generator: single-step and free-run modes driven
// by debounced STEP/MODE buttons, with an enable counter for debug.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned RUN_DIV    = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_step,
    input  logic             btn_mode,
    input  logic             halt_req,
    output logic             cpu_ce,
    output logic             run_mode,
    output logic [CNT_W-1:0] ce_count
);

    localparam int unsigned   RW       = cnt_width(RUN_DIV);
    localparam logic [RW-1:0] RUN_LAST = RW'(RUN_DIV - 1);

    state_t        state;
    state_t        state_nx;
    logic [RW-1:0] run_cnt;
    logic [RW-1:0] run_cnt_nx;
    logic          press_step;
    logic          press_mode;
    logic          unused_step_stable;
    logic          unused_mode_stable;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_step (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_step),
        .btn_stable (unused_step_stable),
        .btn_press  (press_step)
    );

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_mode (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_mode),
        .btn_stable (unused_mode_stable),
        .btn_press  (press_mode)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_HALT;
            run_cnt <= '0;
        end else begin
            state   <= state_nx;
            run_cnt <= run_cnt_nx;
        end
    end

    // run_cnt only advances while staying in RUN; any other path zeroes it.
    always_comb begin
        state_nx   = state;
        run_cnt_nx = '0;
        case (state)
            ST_HALT: begin
                if (press_mode)
                    state_nx = ST_RUN;
                else if (press_step)
                    state_nx = ST_STEP;
            end
            ST_STEP: state_nx = ST_HALT;
            ST_RUN: begin
                if (halt_req || press_mode)
                    state_nx = ST_HALT;
                else
                    run_cnt_nx = (run_cnt == RUN_LAST) ? '0 : run_cnt + 1'b1;
            end
            default: state_nx = ST_HALT;
        endcase
    end

    assign cpu_ce   = (state == ST_STEP) || ((state == ST_RUN) && (run_cnt == RUN_LAST));
    assign run_mode = (state == ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ce_count <= '0;
        else if (cpu_ce)
            ce_count <= ce_count + 1'b1;
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl (DEB_CYCLES=4, RUN_DIV=3, CNT_W=8):
// expected enable pulses are queued by stimulus and popped by a monitor.
module tb_cpu_step_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_step;
    logic       btn_mode;
    logic       halt_req;
    logic       cpu_ce;
    logic       run_mode;
    logic [7:0] ce_count;

    typedef struct {
        int         t;
        logic [7:0] cnt;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] exp_cnt;

    cpu_step_ctrl #(
        .DEB_CYCLES (4),
        .RUN_DIV    (3),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_step (btn_step),
        .btn_mode (btn_mode),
        .halt_req (halt_req),
        .cpu_ce   (cpu_ce),
        .run_mode (run_mode),
        .ce_count (ce_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected ce_count seen during a pulse is the count before it increments.
    task automatic push_pulse(input int t);
        exp_t e;
        e.t = t;
        e.cnt = exp_cnt;
        q.push_back(e);
        exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (cpu_ce === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ce: pulse at cycle %0d count %0d, none expected", cyc, ce_count);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("ce_cycle", cyc, e.t);
                check("ce_count_at_pulse", {24'd0, ce_count}, {24'd0, e.cnt});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int n;
        rst = 1'b0;
        btn_step = 1'b0;
        btn_mode = 1'b0;
        halt_req = 1'b0;
        exp_cnt = 8'd0;

        // Reset state, then idle with no buttons
        repeat (3) @(negedge clk);
        check("rst_cpu_ce", cpu_ce, 0);
        check("rst_run_mode", run_mode, 0);
        check("rst_ce_count", ce_count, 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_cpu_ce", cpu_ce, 0);
        check("idle_run_mode", run_mode, 0);
        check("idle_ce_count", ce_count, 0);

        // Single step: press at edge 5, STEP enable between edges 6 and 7
        c0 = cyc;
        btn_step = 1'b1;
        push_pulse(c0 + 7);
        repeat (10) @(negedge clk);
        btn_step = 1'b0;
        repeat (15) @(negedge clk);
        check("step_queue_empty", q.size(), 0);
        check("step_ce_count", ce_count, 1);

        // Bounce rejection
        repeat (5) begin
            btn_step = 1'b1;
            repeat (2) @(negedge clk);
            btn_step = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (15) @(negedge clk);
        check("bounce_ce_count", ce_count, 1);
        check("bounce_run_mode", run_mode, 0);

        // Run/stop: RUN entered at c0+7, ticks at c0+9+3k, MODE at c0+40 stops after c0+46
        c0 = cyc;
        for (int t = c0 + 9; t <= c0 + 46; t += 3) push_pulse(t);
        btn_mode = 1'b1;
        repeat (6) @(negedge clk);
        btn_mode = 1'b0;
        wait_until(c0 + 6);
        check("run_not_yet", run_mode, 0);
        wait_until(c0 + 7);
        check("run_entered", run_mode, 1);
        wait_until(c0 + 20);
        btn_step = 1'b1;
        repeat (6) @(negedge clk);
        btn_step = 1'b0;
        wait_until(c0 + 40);
        btn_mode = 1'b1;
        wait_until(c0 + 46);
        check("run_before_stop", run_mode, 1);
        btn_mode = 1'b0;
        wait_until(c0 + 47);
        check("run_stopped", run_mode, 0);
        repeat (20) @(negedge clk);
        check("run_queue_empty", q.size(), 0);
        check("run_ce_count", ce_count, 14);

        // halt_req on a tick cycle: that tick fires, then HALT
        c0 = cyc;
        push_pulse(c0 + 9);
        push_pulse(c0 + 12);
        btn_mode = 1'b1;
        repeat (6) @(negedge clk);
        btn_mode = 1'b0;
        wait_until(c0 + 12);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        check("halt_run_mode", run_mode, 0);
        check("halt_cpu_ce", cpu_ce, 0);
        repeat (15) @(negedge clk);
        check("halt_queue_empty", q.size(), 0);

        // Simultaneous STEP+MODE press: MODE wins, no STEP pulse
        c0 = cyc;
        push_pulse(c0 + 9);
        push_pulse(c0 + 12);
        push_pulse(c0 + 15);
        btn_step = 1'b1;
        btn_mode = 1'b1;
        repeat (6) @(negedge clk);
        btn_step = 1'b0;
        btn_mode = 1'b0;
        wait_until(c0 + 7);
        check("both_run_mode", run_mode, 1);
        wait_until(c0 + 16);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        check("both_halted", run_mode, 0);
        repeat (15) @(negedge clk);
        check("both_queue_empty", q.size(), 0);

        // Preload to 255 in RUN, then one step wraps ce_count to 0
        n = 255 - int'(exp_cnt);
        c0 = cyc;
        for (int k = 0; k < n; k++) push_pulse(c0 + 9 + 3 * k);
        btn_mode = 1'b1;
        repeat (6) @(negedge clk);
        btn_mode = 1'b0;
        wait_until(c0 + 9 + 3 * (n - 1));
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        repeat (5) @(negedge clk);
        check("preload_ce_count", ce_count, 255);
        c0 = cyc;
        btn_step = 1'b1;
        push_pulse(c0 + 7);
        repeat (8) @(negedge clk);
        btn_step = 1'b0;
        repeat (15) @(negedge clk);
        check("wrap_ce_count", ce_count, 0);
        check("wrap_queue_empty", q.size(), 0);

        // Asynchronous reset while a RUN tick is being presented
        c0 = cyc;
        push_pulse(c0 + 9);
        push_pulse(c0 + 12);
        btn_mode = 1'b1;
        repeat (6) @(negedge clk);
        btn_mode = 1'b0;
        wait_until(c0 + 12);
        check("mid_run_mode", run_mode, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_cpu_ce", cpu_ce, 0);
        check("arst_run_mode", run_mode, 0);
        check("arst_ce_count", ce_count, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = 8'd0;
        repeat (10) @(negedge clk);
        check("post_rst_queue_empty", q.size(), 0);
        check("post_rst_ce_count", ce_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
